instr_register_reader: RTL and testbench

- Read-side sequencer for the instruction register. It is the counterpart of the write-side stimulus that loads the register over load_en and write_pointer.
- On a start command it walks read_pointer over a programmed address window, either ascending or descending, with modulo-32 wrap.
- It captures each returned instruction_word and delivers it, tagged with its address, on a valid/ready output stream.
- It sits between the instruction register read port and any downstream consumer, such as an execute stage or a scoreboard monitor.

---
 rtl/instr_register_pkg.sv | 36 +++
 rtl/instr_reader_buf.sv | 72 +++++++
 rtl/instr_register_reader.sv | 109 ++++++++++
 tb/tb_instr_register_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side sequencer.
package instr_register_pkg;

    localparam int DEPTH            = 32;
    localparam int ADDR_W           = $clog2(DEPTH);
    localparam int CNT_W            = ADDR_W + 1;
    localparam int READER_BUF_DEPTH = 2;

    typedef logic [ADDR_W-1:0] address_t;
    typedef logic [31:0]       instruction_t;

    typedef enum logic {
        ORDER_INC = 1'b0,
        ORDER_DEC = 1'b1
    } read_order_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    typedef struct packed {
        instruction_t instr;
        address_t     addr;
    } reader_entry_t;

    // One address step in the requested direction, wrapping modulo DEPTH.
    function automatic address_t step_addr(input address_t a, input read_order_t o);
        if (o == ORDER_DEC) begin
            return (a == '0) ? address_t'(DEPTH - 1) : a - address_t'(1);
        end
        return (a == address_t'(DEPTH - 1)) ? '0 : a + address_t'(1);
    endfunction

endpackage

// File: rtl/instr_reader_buf.sv
// Small synchronous FIFO of captured {instruction, address} entries with a
// valid/ready read side and a flush that empties it in one edge.
module instr_reader_buf
    import instr_register_pkg::*;
#(
    parameter int BUF_DEPTH = READER_BUF_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  reader_entry_t push_data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output reader_entry_t data_o,
    output logic          full_o,
    output logic          last_o
);

    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int BCNT_W = $clog2(BUF_DEPTH + 1);

    reader_entry_t     mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic              pop;
    logic              push_ok;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == BCNT_W'(BUF_DEPTH));
    assign last_o  = (cnt_q == BCNT_W'(1));
    assign data_o  = mem_q[rd_ptr_q];
    assign pop     = valid_o && ready_i;
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign push_ok = push_i && (!full_o || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = bump(wr_ptr_q);
            if (pop)     rd_ptr_d = bump(rd_ptr_q);
            if (push_ok && !pop)      cnt_d = cnt_q + BCNT_W'(1);
            else if (!push_ok && pop) cnt_d = cnt_q - BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_register_reader.sv
// Read-side sequencer: walks read_pointer over an address window and streams
// the returned words, tagged with their address, over valid/ready.
module instr_register_reader
    import instr_register_pkg::*;
#(
    parameter int BUF_DEPTH = READER_BUF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  address_t         start_addr,
    input  logic [CNT_W-1:0] count,
    input  read_order_t      order,
    output address_t         read_pointer,
    input  instruction_t     instruction_word,
    output logic             out_valid,
    input  logic             out_ready,
    output instruction_t     out_instr,
    output address_t         out_addr,
    output logic             busy,
    output logic             done,
    output logic             start_err
);

    reader_state_t    state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    read_order_t      order_q, order_d;
    address_t         rp_q, rp_d;

    logic          buf_full, buf_last, buf_flush, pop, capture, count_ok;
    reader_entry_t buf_head;

    // Handshake: an entry moves when out_valid && out_ready on a rising edge;
    // the head is held stable until then, and only abort/reset drop it.
    assign pop       = out_valid && out_ready;
    assign count_ok  = (count != '0) && (count <= CNT_W'(DEPTH));
    assign buf_flush = abort && (state_q != IDLE);
    assign capture   = (state_q == ISSUE) && !abort && (!buf_full || pop);

    instr_reader_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (buf_flush),
        .push_i      (capture),
        .push_data_i ('{instr: instruction_word, addr: rp_q}),
        .ready_i     (out_ready),
        .valid_o     (out_valid),
        .data_o      (buf_head),
        .full_o      (buf_full),
        .last_o      (buf_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            order_q <= ORDER_INC;
            rp_q    <= '1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            order_q <= order_d;
            rp_q    <= rp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        order_d = order_q;
        rp_d    = rp_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort && count_ok) begin
                    state_d = ISSUE;
                    rem_d   = count;
                    order_d = order;
                    rp_d    = start_addr;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (capture) begin
                    rp_d  = step_addr(rp_q, order_q);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort || (pop && buf_last)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        done         = (state_q == DRAIN) && !abort && pop && buf_last;
        // Abort wins over a simultaneous start in IDLE and silences it.
        start_err    = start && ((state_q != IDLE) || (!abort && !count_ok));
        read_pointer = rp_q;
        out_instr    = buf_head.instr;
        out_addr     = buf_head.addr;
    end

endmodule

// File: tb/tb_instr_register_reader.sv
// Bench for instr_register_reader: queue-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_register_reader;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, abort;
    address_t     start_addr;
    logic [5:0]   count;
    read_order_t  order;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         out_valid, out_ready;
    instruction_t out_instr;
    address_t     out_addr;
    logic         busy, done, start_err;

    instruction_t mem [DEPTH];

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_register_reader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .start_addr       (start_addr),
        .count            (count),
        .order            (order),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_addr         (out_addr),
        .busy             (busy),
        .done             (done),
        .start_err        (start_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    reader_entry_t iss_q[$];
    reader_entry_t buf_q[$];
    address_t      got_q[$];
    address_t      m_rp    = 5'h1F;
    logic          m_busy  = 1'b0;
    logic          m_dec   = 1'b0;
    int            cyc     = 0;
    int            done_cnt = 0;
    int            start_cyc = 0;
    int            done_cyc  = 0;

    logic          hs, cap, exp_done, exp_err, bad_cnt, busy_now;
    reader_entry_t e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            iss_q.delete();
            buf_q.delete();
            m_rp   = 5'h1F;
            m_busy = 1'b0;
        end else begin
            busy_now = m_busy;
            bad_cnt  = (count == 6'd0) || (count > 6'd32);
            hs       = (buf_q.size() > 0) && out_ready && !(abort && busy_now);
            exp_done = hs && busy_now && (iss_q.size() == 0) && (buf_q.size() == 1);
            exp_err  = start && !(abort && !busy_now) && (busy_now || bad_cnt);

            chk("busy", 32'(busy), 32'(busy_now));
            chk("out_valid", 32'(out_valid), 32'(buf_q.size() > 0));
            chk("read_pointer", 32'(read_pointer), 32'(m_rp));
            chk("done", 32'(done), 32'(exp_done));
            chk("start_err", 32'(start_err), 32'(exp_err));
            if (buf_q.size() > 0) begin
                chk("out_addr", 32'(out_addr), 32'(buf_q[0].addr));
                chk("out_instr", out_instr, buf_q[0].instr);
            end
            if (out_valid && out_ready && !abort) got_q.push_back(out_addr);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end

            if (abort && busy_now) begin
                iss_q.delete();
                buf_q.delete();
                m_busy = 1'b0;
            end else begin
                cap = (iss_q.size() > 0) && ((buf_q.size() < READER_BUF_DEPTH) || hs);
                if (hs) void'(buf_q.pop_front());
                if (cap) begin
                    e = iss_q.pop_front();
                    buf_q.push_back(e);
                    m_rp = m_dec ? e.addr - 5'd1 : e.addr + 5'd1;
                end
                if (exp_done) m_busy = 1'b0;
                if (start && !abort && !busy_now && !bad_cnt) begin
                    m_dec = (order == ORDER_DEC);
                    for (int i = 0; i < int'(count); i++) begin
                        e.addr  = m_dec ? start_addr - address_t'(i) : start_addr + address_t'(i);
                        e.instr = mem[e.addr];
                        iss_q.push_back(e);
                    end
                    m_rp      = start_addr;
                    m_busy    = 1'b1;
                    start_cyc = cyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_got();
        logic [31:0] r;
        r = '0;
        foreach (got_q[i]) r = {r[26:0], got_q[i]};
        return r;
    endfunction

    task automatic run_seq(input int sa, input int cnt, input logic dec,
                           input int st_lo, input int st_hi, input int intr,
                           output int lat);
        int d0;
        got_q.delete();
        d0         = done_cnt;
        start      = 1'b1;
        abort      = 1'b0;
        start_addr = address_t'(sa);
        count      = 6'(cnt);
        order      = dec ? ORDER_DEC : ORDER_INC;
        out_ready  = 1'b1;
        tick();
        for (int i = 1; i <= 300 && done_cnt == d0; i++) begin
            start     = 1'b0;
            out_ready = !(i >= st_lo && i <= st_hi);
            if (i == intr) begin
                start      = 1'b1;
                start_addr = 5'd0;
                count      = 6'd3;
                #1;
                chk("start_err_busy", 32'(start_err), 32'd1);
            end
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        tick();
        tick();
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        lat = done_cyc - start_cyc;
    endtask

    // ---------------- stimulus ----------------
    int lat, lat_free, d0, r;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        start_addr = '0;
        count      = '0;
        order      = ORDER_INC;
        out_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();

        tick();
        chk("rst_read_pointer", 32'(read_pointer), 32'h1F);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_start_err", 32'(start_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        run_seq(0, 4, 1'b0, 100, 0, 0, lat);
        chk("inc_addrs", pack_got(), 32'({5'd0, 5'd1, 5'd2, 5'd3}));
        chk("inc_latency", 32'(lat), 32'd5);

        run_seq(30, 4, 1'b0, 100, 0, 0, lat);
        chk("wrap_inc_addrs", pack_got(), 32'({5'd30, 5'd31, 5'd0, 5'd1}));

        run_seq(1, 3, 1'b1, 100, 0, 0, lat);
        chk("wrap_dec_addrs", pack_got(), 32'({5'd1, 5'd0, 5'd31}));

        run_seq(10, 6, 1'b0, 100, 0, 0, lat_free);
        run_seq(10, 6, 1'b0, 3, 5, 0, lat);
        chk("stall_addrs", pack_got(), 32'({5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15}));
        chk("stall_delay", 32'(lat - lat_free), 32'd3);

        // count == 0 is rejected in IDLE
        start = 1'b1; count = 6'd0; start_addr = 5'd4;
        #1;
        chk("zero_count_err", 32'(start_err), 32'd1);
        tick();
        start = 1'b0;
        chk("zero_count_idle", 32'(busy), 32'd0);
        tick();

        run_seq(20, 5, 1'b0, 100, 0, 3, lat);
        chk("busy_start_addrs", pack_got(), 32'({5'd20, 5'd21, 5'd22, 5'd23, 5'd24}));

        // start and abort together in IDLE: silently ignored
        start = 1'b1; abort = 1'b1; count = 6'd4;
        #1;
        chk("idle_abort_start_err", 32'(start_err), 32'd0);
        tick();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        tick();

        // abort after two transfers
        got_q.delete();
        d0 = done_cnt;
        start = 1'b1; start_addr = 5'd5; count = 6'd8; order = ORDER_INC; out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1; out_ready = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_transfers", 32'(got_q.size()), 32'd2);
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        run_seq(7, 1, 1'b1, 100, 0, 0, lat);
        chk("after_abort_addr", pack_got(), 32'd7);
        chk("after_done_rp", 32'(read_pointer), 32'd6);

        run_seq(17, 32, 1'b1, 100, 0, 0, lat);
        chk("full_window_len", 32'(got_q.size()), 32'd32);
        chk("full_window_latency", 32'(lat), 32'd33);
        chk("full_window_rp", 32'(read_pointer), 32'd17);

        // asynchronous reset in the middle of a sequence
        d0 = done_cnt;
        start = 1'b1; start_addr = 5'd3; count = 6'd10; order = ORDER_INC;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_rp", 32'(read_pointer), 32'h1F);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("async_rst_no_done", 32'(done_cnt - d0), 32'd0);

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            start = 1'b0;
            abort = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!m_busy && $urandom_range(0, 4) == 0) begin
                start      = 1'b1;
                start_addr = address_t'($urandom_range(0, 31));
                order      = read_order_t'($urandom_range(0, 1));
                r = $urandom_range(0, 9);
                if (r == 0)      count = 6'd0;
                else if (r == 1) count = 6'($urandom_range(33, 63));
                else             count = 6'($urandom_range(1, 32));
                if ($urandom_range(0, 15) == 0) abort = 1'b1;
            end else if (m_busy) begin
                r = $urandom_range(0, 99);
                if (r < 2) begin
                    abort     = 1'b1;
                    out_ready = 1'b0;
                end else if (r < 5) begin
                    start = 1'b1;
                    count = 6'($urandom_range(0, 63));
                end
            end
            tick();
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 200 && m_busy; i++) tick();
        tick();
        chk("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
